axil_ls_arbiter: RTL and testbench
==================================

# axil_ls_arbiter

Arbitrates two backdoor-style command requesters onto one AXI-Lite master port toward the LS (AXI-Lite slave) side. Requesters use the start/done command protocol of the LS backdoor (write: start/addr/data/strb → done; read: start/addr → data/done). The block serialises transactions and grants round-robin. A per-transaction timeout returns an error instead of hanging a requester.

## Interface
Parameters:
- ADDR_WIDTH, 15, AXI-Lite address width
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, cycles a transaction may stay outstanding before forced completion

Ports:
- axi_aclk  in  1  clock
- axi_reset  in  1  reset, synchronous, active-high
- enable  in  1  when low, no new grant is issued; an in-flight transaction still completes
- reqN_wstart  in  1  write request, level, N∈{0,1}
- reqN_waddr  in  ADDR_WIDTH  write address
- reqN_wdata  in  DATA_WIDTH  write data
- reqN_wstrb  in  DATA_WIDTH/8  write strobe
- reqN_wdone  out  1  one-cycle write completion pulse
- reqN_rstart  in  1  read request, level
- reqN_raddr  in  ADDR_WIDTH  read address
- reqN_rdata  out  DATA_WIDTH  read data, valid with rdone
- reqN_rdone  out  1  one-cycle read completion pulse
- reqN_err  out  1  high with done when the transaction timed out
- m_awvalid/m_awaddr/m_awready  out/out/in  1/ADDR_WIDTH/1  AW channel
- m_wvalid/m_wdata/m_wstrb/m_wready  out/out/out/in  1/DATA_WIDTH/DATA_WIDTH/8/1  W channel
- m_arvalid/m_araddr/m_arready  out/out/in  1/ADDR_WIDTH/1  AR channel
- m_rvalid/m_rdata/m_rready  in/in/out  1/DATA_WIDTH/1  R channel

## Operation
- Requester holds start, address, data and strobe stable until its done pulse, then drops start within 1 cycle.
- FSM states: IDLE, WRITE, RD_ADDR, RD_DATA, DONE.
- IDLE: if enable is high and any start is high, grant and latch address, data and strobe.
  - Both requesters active: grant the one not granted last. last_grant resets to 1, so req0 wins the first conflict.
  - Same requester with both wstart and rstart high: the write goes first.
- WRITE: m_awvalid and m_wvalid rise together.
  - Each valid drops independently on its own ready.
  - When both channels have been accepted (same cycle or different cycles), go to DONE with a write result.
- RD_ADDR: m_arvalid is high. On m_arready, go to RD_DATA.
- RD_DATA: m_rready is high. On m_rvalid, capture m_rdata and go to DONE.
- DONE: pulse the granted requester's wdone or rdone (and err if the transaction timed out) for 1 cycle, then return to IDLE.
- Timeout:
  - An 8+ bit counter clears on grant and increments in WRITE, RD_ADDR and RD_DATA.
  - When it reaches TIMEOUT_CYCLES: drop all m_*valid and m_rready, set err, set rdata to all-ones, and go to DONE.
- reqN_rdata holds its last captured value until the next read completes for that requester.
- The block has no B channel; a write completes on AW+W acceptance.

## Timing
- Reset values:
  - All m_*valid = 0, m_rready = 0, addresses/data = 0.
  - All done/err = 0, all rdata = 0.
  - State = IDLE, counter = 0.
- Latency:
  - Start seen in IDLE at cycle N → m_*valid high at N+1.
  - Write with zero-wait ready: valids accepted at N+1, done pulse at N+2.
  - Read with zero-wait: AR accepted at N+1, rvalid at N+2, rdone at N+3.
- No combinational path from any input to any output; all outputs are registered.
- A request arriving in the DONE cycle is evaluated in the following IDLE cycle.
- enable falling mid-transaction: no effect until return to IDLE.
- Reset mid-transaction: all outputs return to reset values next cycle, with no done pulse. A still-held start is re-arbitrated after reset.
- Timeout boundary: a ready or rvalid arriving in the same cycle the counter hits TIMEOUT_CYCLES completes normally (err = 0).

## Structure
- Package axil_ls_arbiter_pkg holds:
  - state enum (IDLE, WRITE, RD_ADDR, RD_DATA, DONE)
  - default ADDR_WIDTH and DATA_WIDTH
  - timeout error data constant (all-ones)
- Sub-module rr_arb2: 2-way round-robin grant with a last_grant flop, updated only on grant.

## Test plan
- req0 write addr 0x0100, data 0xDEADBEEF, strb 0xF; ready tied high → AW/W at N+1, req0_wdone at N+2, err = 0.
- req1 read addr 0x0200; slave returns 0x12345678 after 3 wait cycles → req1_rdata = 0x12345678 with req1_rdone, m_rready high only in RD_DATA.
- req0 and req1 both assert writes in the same cycle, repeated 4 times → grants alternate 0,1,0,1; no overlapping valids.
- awready at N+1, wready at N+4 → awvalid drops at N+2, wvalid drops at N+5, wdone at N+5.
- Read with arready never asserted, TIMEOUT_CYCLES = 16 → arvalid drops; rdone with err = 1 and rdata = 0xFFFFFFFF at the timeout cycle +1.
- axi_reset asserted in RD_DATA with start held → no rdone, outputs reset; the read reissues after reset release.

Source files
------------

// File: rtl/axil_ls_arbiter_pkg.sv
// rtl/axil_ls_arbiter_pkg.sv - shared types and constants for the LS backdoor arbiter
package axil_ls_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 15;
    localparam int DEF_DATA_WIDTH = 32;

    // Replicated across the data width to form the all-ones read data of a timed-out read
    localparam logic TIMEOUT_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_ADDR = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

// File: rtl/axil_ls_arbiter_rr_arb2.sv
// rtl/axil_ls_arbiter_rr_arb2.sv - 2-way round-robin grant with a last-grant flop
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output logic gnt_valid,
    output logic gnt_idx
);

    logic last_q;

    always_comb begin
        gnt_valid = req0 | req1;
        // On conflict favour whoever was not served last; otherwise serve the lone requester
        if (req0 && req1) begin
            gnt_idx = ~last_q;
        end else begin
            gnt_idx = req1;
        end
    end

    // Resets to 1 so requester 0 wins the first conflict
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (take && gnt_valid) begin
            last_q <= gnt_idx;
        end
    end

endmodule

// File: rtl/axil_ls_arbiter.sv
// rtl/axil_ls_arbiter.sv - two-requester backdoor command arbiter onto one AXI-Lite master port
module axil_ls_arbiter
    import axil_ls_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    axi_aclk,
    input  logic                    axi_reset,
    input  logic                    enable,

    input  logic                    req0_wstart,
    input  logic [ADDR_WIDTH-1:0]   req0_waddr,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    input  logic [DATA_WIDTH/8-1:0] req0_wstrb,
    output logic                    req0_wdone,
    input  logic                    req0_rstart,
    input  logic [ADDR_WIDTH-1:0]   req0_raddr,
    output logic [DATA_WIDTH-1:0]   req0_rdata,
    output logic                    req0_rdone,
    output logic                    req0_err,

    input  logic                    req1_wstart,
    input  logic [ADDR_WIDTH-1:0]   req1_waddr,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    input  logic [DATA_WIDTH/8-1:0] req1_wstrb,
    output logic                    req1_wdone,
    input  logic                    req1_rstart,
    input  logic [ADDR_WIDTH-1:0]   req1_raddr,
    output logic [DATA_WIDTH-1:0]   req1_rdata,
    output logic                    req1_rdone,
    output logic                    req1_err,

    output logic                    m_awvalid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    input  logic                    m_awready,
    output logic                    m_wvalid,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_wready,
    output logic                    m_arvalid,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    input  logic                    m_arready,
    input  logic                    m_rvalid,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    output logic                    m_rready
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_BITS   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_WIDTH  = (CNT_BITS > 8) ? CNT_BITS : 8;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    state_e                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                    cnt_hit;
    logic                    gnt_q, gnt_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0]   rdata_q [2];
    logic [DATA_WIDTH-1:0]   rdata_d [2];
    logic [1:0]              wdone_q, wdone_d;
    logic [1:0]              rdone_q, rdone_d;
    logic [1:0]              err_q, err_d;

    logic                    arb_take, arb_valid, arb_idx;
    logic                    sel_wr;
    logic [ADDR_WIDTH-1:0]   sel_waddr, sel_raddr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [STRB_WIDTH-1:0]   sel_wstrb;
    logic                    aw_ok, w_ok;

    rr_arb2 u_arb (
        .clk       (axi_aclk),
        .rst       (axi_reset),
        .req0      (req0_wstart | req0_rstart),
        .req1      (req1_wstart | req1_rstart),
        .take      (arb_take),
        .gnt_valid (arb_valid),
        .gnt_idx   (arb_idx)
    );

    // A requester with both starts high is served as a write first
    assign sel_wr    = arb_idx ? req1_wstart : req0_wstart;
    assign sel_waddr = arb_idx ? req1_waddr  : req0_waddr;
    assign sel_wdata = arb_idx ? req1_wdata  : req0_wdata;
    assign sel_wstrb = arb_idx ? req1_wstrb  : req0_wstrb;
    assign sel_raddr = arb_idx ? req1_raddr  : req0_raddr;

    // Saturating so an acceptance exactly at the limit still leaves a detectable hit later
    assign cnt_hit = (cnt_q == CNT_LIMIT);
    assign cnt_inc = cnt_hit ? cnt_q : cnt_q + CNT_WIDTH'(1);

    // A channel counts as accepted once its valid has dropped or it handshakes now
    assign aw_ok = !awvalid_q || m_awready;
    assign w_ok  = !wvalid_q  || m_wready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;
        rdata_d   = rdata_q;
        wdone_d   = '0;
        rdone_d   = '0;
        err_d     = '0;
        arb_take  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable && arb_valid) begin
                    arb_take = 1'b1;
                    gnt_d    = arb_idx;
                    cnt_d    = '0;
                    if (sel_wr) begin
                        state_d   = ST_WRITE;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = sel_waddr;
                        wdata_d   = sel_wdata;
                        wstrb_d   = sel_wstrb;
                    end else begin
                        state_d   = ST_RD_ADDR;
                        arvalid_d = 1'b1;
                        araddr_d  = sel_raddr;
                    end
                end
            end

            ST_WRITE: begin
                if (m_awready) awvalid_d = 1'b0;
                if (m_wready)  wvalid_d  = 1'b0;
                if (aw_ok && w_ok) begin
                    wdone_d[gnt_q] = 1'b1;
                    state_d        = ST_DONE;
                end else if (cnt_hit) begin
                    awvalid_d      = 1'b0;
                    wvalid_d       = 1'b0;
                    wdone_d[gnt_q] = 1'b1;
                    err_d[gnt_q]   = 1'b1;
                    state_d        = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_RD_ADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    cnt_d     = cnt_inc;
                    state_d   = ST_RD_DATA;
                end else if (cnt_hit) begin
                    arvalid_d      = 1'b0;
                    rdata_d[gnt_q] = {DATA_WIDTH{TIMEOUT_FILL}};
                    rdone_d[gnt_q] = 1'b1;
                    err_d[gnt_q]   = 1'b1;
                    state_d        = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_RD_DATA: begin
                if (m_rvalid) begin
                    rready_d       = 1'b0;
                    rdata_d[gnt_q] = m_rdata;
                    rdone_d[gnt_q] = 1'b1;
                    state_d        = ST_DONE;
                end else if (cnt_hit) begin
                    rready_d       = 1'b0;
                    rdata_d[gnt_q] = {DATA_WIDTH{TIMEOUT_FILL}};
                    rdone_d[gnt_q] = 1'b1;
                    err_d[gnt_q]   = 1'b1;
                    state_d        = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gnt_q      <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            araddr_q   <= '0;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
            wdone_q    <= '0;
            rdone_q    <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            rready_q   <= rready_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            araddr_q   <= araddr_d;
            rdata_q    <= rdata_d;
            wdone_q    <= wdone_d;
            rdone_q    <= rdone_d;
            err_q      <= err_d;
        end
    end

    assign m_awvalid  = awvalid_q;
    assign m_awaddr   = awaddr_q;
    assign m_wvalid   = wvalid_q;
    assign m_wdata    = wdata_q;
    assign m_wstrb    = wstrb_q;
    assign m_arvalid  = arvalid_q;
    assign m_araddr   = araddr_q;
    assign m_rready   = rready_q;

    assign req0_wdone = wdone_q[0];
    assign req0_rdone = rdone_q[0];
    assign req0_err   = err_q[0];
    assign req0_rdata = rdata_q[0];
    assign req1_wdone = wdone_q[1];
    assign req1_rdone = rdone_q[1];
    assign req1_err   = err_q[1];
    assign req1_rdata = rdata_q[1];

endmodule

// File: tb/tb_axil_ls_arbiter.sv
// tb/tb_axil_ls_arbiter.sv - scoreboard bench for the LS backdoor arbiter
module tb_axil_ls_arbiter;

    localparam int AW = 15;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int TO = 16;

    typedef struct {
        bit              wr;
        bit              err;
        logic [DW-1:0]   rdata;
        logic [AW-1:0]   addr;
        logic [DW-1:0]   data;
        logic [SW-1:0]   strb;
        int              cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          axi_reset = 1'b1;
    logic          enable = 1'b1;
    logic          wstart [2];
    logic          rstart [2];
    logic [AW-1:0] waddr [2];
    logic [AW-1:0] raddr [2];
    logic [DW-1:0] wdata [2];
    logic [SW-1:0] wstrb [2];
    logic          wdone [2];
    logic          rdone [2];
    logic          err [2];
    logic [DW-1:0] rdata [2];

    logic          m_awvalid, m_wvalid, m_arvalid, m_rready;
    logic [AW-1:0] m_awaddr, m_araddr;
    logic [DW-1:0] m_wdata;
    logic [SW-1:0] m_wstrb;
    logic          m_awready = 1'b0;
    logic          m_wready = 1'b0;
    logic          m_arready = 1'b0;
    logic          m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;

    axil_ls_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .axi_aclk(clk), .axi_reset(axi_reset), .enable(enable),
        .req0_wstart(wstart[0]), .req0_waddr(waddr[0]), .req0_wdata(wdata[0]), .req0_wstrb(wstrb[0]),
        .req0_wdone(wdone[0]), .req0_rstart(rstart[0]), .req0_raddr(raddr[0]), .req0_rdata(rdata[0]),
        .req0_rdone(rdone[0]), .req0_err(err[0]),
        .req1_wstart(wstart[1]), .req1_waddr(waddr[1]), .req1_wdata(wdata[1]), .req1_wstrb(wstrb[1]),
        .req1_wdone(wdone[1]), .req1_rstart(rstart[1]), .req1_raddr(raddr[1]), .req1_rdata(rdata[1]),
        .req1_rdone(rdone[1]), .req1_err(err[1]),
        .m_awvalid(m_awvalid), .m_awaddr(m_awaddr), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wready(m_wready),
        .m_arvalid(m_arvalid), .m_araddr(m_araddr), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rready(m_rready)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    exp_t q0 [$];
    exp_t q1 [$];
    logic [AW-1:0] exp_aw_q [$];

    // Slave behaviour knobs: per-channel wait in cycles after valid/rready rises
    bit   cfg_rand = 1'b0;
    int   cfg_aw = 0, cfg_w = 0, cfg_ar = 0, cfg_r = 0;
    bit   ovr_en = 1'b0;
    logic [DW-1:0] ovr_val = '0;

    logic [AW-1:0] log_aw = '0, log_ar = '0;
    logic [DW-1:0] log_wd = '0;
    logic [SW-1:0] log_ws = '0;
    bit prev_aw_hs = 1'b0, prev_w_hs = 1'b0, prev_ar_hs = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] slave_val(input logic [AW-1:0] a);
        return {a, 2'b10, ~a};
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference timing: a write finishes once the later channel is accepted; a read once
    // AR then R are both done. Anything still open when TO cycles have elapsed times out.
    function automatic int wr_rel(input int a, input int b);
        return (max2(a, b) <= TO) ? 2 + max2(a, b) : TO + 2;
    endfunction
    function automatic bit wr_err(input int a, input int b);
        return max2(a, b) > TO;
    endfunction
    function automatic bit rd_ok(input int ka, input int kr);
        return (ka < TO) && (ka + 1 + kr <= TO);
    endfunction
    function automatic int rd_rel(input int ka, input int kr);
        return rd_ok(ka, kr) ? 3 + ka + kr : TO + 2;
    endfunction

    // Slave: drives ready/rvalid shortly after each rising edge
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
    int aw_wt = 0, w_wt = 0, ar_wt = 0, r_wt = 0;
    bit aw_act = 0, w_act = 0, ar_act = 0, r_act = 0;
    always @(posedge clk) begin
        #1;
        if (m_awvalid) begin
            if (!aw_act) begin aw_act = 1; aw_cnt = 0; aw_wt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_aw; end
            m_awready = (aw_cnt == aw_wt); aw_cnt++;
        end else begin aw_act = 0; m_awready = 1'b0; end
        if (m_wvalid) begin
            if (!w_act) begin w_act = 1; w_cnt = 0; w_wt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_w; end
            m_wready = (w_cnt == w_wt); w_cnt++;
        end else begin w_act = 0; m_wready = 1'b0; end
        if (m_arvalid) begin
            if (!ar_act) begin ar_act = 1; ar_cnt = 0; ar_wt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_ar; end
            m_arready = (ar_cnt == ar_wt); ar_cnt++;
        end else begin ar_act = 0; m_arready = 1'b0; end
        if (m_rready) begin
            if (!r_act) begin r_act = 1; r_cnt = 0; r_wt = cfg_rand ? int'($urandom_range(0, 3)) : cfg_r; end
            m_rvalid = (r_cnt == r_wt); r_cnt++;
            m_rdata = ovr_en ? ovr_val : slave_val(log_ar);
        end else begin r_act = 0; m_rvalid = 1'b0; end
    end

    task automatic score(input int r, input bit is_wr);
        exp_t e;
        if (r == 0) begin
            if (q0.size() == 0) begin check("unexpected_done0", 1, 0); return; end
            e = q0.pop_front();
        end else begin
            if (q1.size() == 0) begin check("unexpected_done1", 1, 0); return; end
            e = q1.pop_front();
        end
        check("done_kind", is_wr, e.wr);
        check("done_err", err[r], e.err);
        if (is_wr) begin
            if (!e.err) begin
                check("wr_addr", log_aw, e.addr);
                check("wr_data", log_wd, e.data);
                check("wr_strb", log_ws, e.strb);
            end
        end else begin
            check("rd_data", rdata[r], e.rdata);
            if (!e.err) check("rd_addr", log_ar, e.addr);
        end
        if (e.cyc >= 0) check("done_cycle", cyc, e.cyc);
        check("bus_quiet_at_done", {m_awvalid, m_wvalid, m_arvalid, m_rready}, 0);
    endtask

    // Monitor: handshake log, protocol checks and scoreboard pops
    always @(negedge clk) begin
        if (prev_aw_hs) check("awvalid_drop", m_awvalid, 0);
        if (prev_w_hs)  check("wvalid_drop", m_wvalid, 0);
        if (prev_ar_hs) check("arvalid_drop", m_arvalid, 0);
        prev_aw_hs = m_awvalid && m_awready;
        prev_w_hs  = m_wvalid && m_wready;
        prev_ar_hs = m_arvalid && m_arready;
        if (m_awvalid && m_awready) begin
            log_aw = m_awaddr;
            if (exp_aw_q.size() > 0) check("grant_order", m_awaddr, exp_aw_q.pop_front());
        end
        if (m_wvalid && m_wready) begin log_wd = m_wdata; log_ws = m_wstrb; end
        if (m_arvalid && m_arready) log_ar = m_araddr;
        if (m_awvalid || m_wvalid || m_arvalid || m_rready)
            check("no_overlap", {(m_awvalid | m_wvalid) & (m_arvalid | m_rready), m_arvalid & m_rready}, 0);
        for (int r = 0; r < 2; r++) begin
            if (wdone[r] || rdone[r]) begin
                check("single_done", wdone[r] & rdone[r], 0);
                score(r, wdone[r]);
            end
        end
    end

    task automatic do_txn(input int r, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input int rel, input bit e_err, input logic [DW-1:0] e_rdata);
        exp_t e;
        bit got;
        @(negedge clk);
        e.wr = wr; e.err = e_err; e.rdata = e_rdata; e.addr = addr; e.data = data; e.strb = strb;
        e.cyc = (rel >= 0) ? cyc + rel : -1;
        if (r == 0) q0.push_back(e); else q1.push_back(e);
        if (wr) begin
            waddr[r] = addr; wdata[r] = data; wstrb[r] = strb; wstart[r] = 1'b1;
        end else begin
            raddr[r] = addr; rstart[r] = 1'b1;
        end
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            got = wr ? wdone[r] : rdone[r];
        end
        check("done_seen", got, 1);
        wstart[r] = 1'b0;
        rstart[r] = 1'b0;
    endtask

    task automatic rand_req(input int r, input int n);
        bit            wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        for (int i = 0; i < n; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = AW'($urandom);
            d  = $urandom;
            s  = SW'($urandom_range(1, 15));
            do_txn(r, wr, a, d, s, -1, 1'b0, slave_val(a));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        for (int r = 0; r < 2; r++) begin
            wstart[r] = 0; rstart[r] = 0; waddr[r] = '0; raddr[r] = '0; wdata[r] = '0; wstrb[r] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_awvalid", m_awvalid, 0);
        check("rst_wvalid", m_wvalid, 0);
        check("rst_arvalid", m_arvalid, 0);
        check("rst_rready", m_rready, 0);
        check("rst_addrs", {m_awaddr, m_araddr}, 0);
        check("rst_wdata", {m_wdata, m_wstrb}, 0);
        check("rst_done", {wdone[0], wdone[1], rdone[0], rdone[1], err[0], err[1]}, 0);
        check("rst_rdata", {rdata[0], rdata[1]}, 0);
        axi_reset = 1'b0;

        // Simultaneous writes: req0 wins first conflict, then strict alternation
        for (int i = 0; i < 4; i++) begin
            exp_aw_q.push_back(AW'(15'h0400 + i));
            exp_aw_q.push_back(AW'(15'h0800 + i));
            fork
                do_txn(0, 1'b1, AW'(15'h0400 + i), 32'h1000_0000 + i, 4'hF, -1, 1'b0, '0);
                do_txn(1, 1'b1, AW'(15'h0800 + i), 32'h2000_0000 + i, 4'h5, -1, 1'b0, '0);
            join
        end
        check("grant_order_drained", exp_aw_q.size(), 0);

        cfg_aw = 0; cfg_w = 0;
        do_txn(0, 1'b1, 15'h0100, 32'hDEADBEEF, 4'hF, wr_rel(0, 0), 1'b0, '0);

        ovr_en = 1'b1; ovr_val = 32'h12345678; cfg_ar = 0; cfg_r = 3;
        do_txn(1, 1'b0, 15'h0200, '0, '0, rd_rel(0, 3), 1'b0, 32'h12345678);
        ovr_en = 1'b0;

        cfg_aw = 0; cfg_w = 3;
        do_txn(0, 1'b1, 15'h0111, 32'hA5A55A5A, 4'h9, wr_rel(0, 3), wr_err(0, 3), '0);

        cfg_ar = 1000; cfg_r = 0;
        do_txn(0, 1'b0, 15'h0222, '0, '0, rd_rel(1000, 0), !rd_ok(1000, 0), 32'hFFFFFFFF);

        cfg_aw = 16; cfg_w = 0;
        do_txn(1, 1'b1, 15'h0333, 32'h01020304, 4'hC, wr_rel(16, 0), wr_err(16, 0), '0);
        cfg_aw = 0; cfg_w = 17;
        do_txn(1, 1'b1, 15'h0334, 32'h05060708, 4'h3, wr_rel(0, 17), wr_err(0, 17), '0);
        cfg_ar = 2; cfg_r = 13;
        do_txn(0, 1'b0, 15'h0444, '0, '0, rd_rel(2, 13), !rd_ok(2, 13), slave_val(15'h0444));
        cfg_ar = 2; cfg_r = 14;
        do_txn(1, 1'b0, 15'h0445, '0, '0, rd_rel(2, 14), !rd_ok(2, 14), 32'hFFFFFFFF);

        cfg_aw = 1; cfg_w = 0;
        enable = 1'b0;
        fork
            do_txn(0, 1'b1, 15'h0155, 32'hCAFEF00D, 4'h3, -1, 1'b0, '0);
            begin
                repeat (6) @(negedge clk);
                check("enable_gate_aw", m_awvalid, 0);
                check("enable_gate_done", wdone[0], 0);
                enable = 1'b1;
            end
        join

        cfg_ar = 0; cfg_r = 1000;
        fork
            do_txn(1, 1'b0, 15'h0321, '0, '0, -1, 1'b0, slave_val(15'h0321));
            begin
                seen = 1'b0;
                for (int k = 0; k < 50 && !seen; k++) begin
                    @(negedge clk);
                    seen = m_rready;
                end
                check("reach_rd_data", seen, 1);
                cfg_r = 0;
                axi_reset = 1'b1;
                @(negedge clk);
                check("midrst_rready", m_rready, 0);
                check("midrst_rdone", rdone[1], 0);
                check("midrst_rdata", rdata[1], 0);
                check("midrst_araddr", m_araddr, 0);
                axi_reset = 1'b0;
            end
        join

        cfg_rand = 1'b1;
        fork
            rand_req(0, 20);
            rand_req(1, 20);
        join
        repeat (5) @(negedge clk);
        check("queues_drained", q0.size() + q1.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
